// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants and the fetch FSM state type.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int RS1_HI = 19;
  localparam int RS1_LO = 15;
  localparam int RS2_HI = 24;
  localparam int RS2_LO = 20;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register holding an instruction that arrived while ID was stalled.
module fetch_hold_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic            consume,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, imem handshake, IF/ID register; optional perf counters via FETCH_PERF_EN.
//
// state   | meaning
// S_FETCH | request outstanding at pc, waiting for / accepting the response
// S_HOLD  | response captured in the hold buffer while ID is stalled
// S_DROP  | waiting out the response to an address abandoned by a redirect
module fetch_unit #(
  parameter int              XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr,
  output logic            IF_ID_valid,
  output logic [4:0]      IF_ID_Rs1,
  output logic [4:0]      IF_ID_Rs2
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);

  import rv_pkg::fetch_state_t;
  import rv_pkg::S_FETCH;
  import rv_pkg::S_HOLD;
  import rv_pkg::S_DROP;
  import rv_pkg::RS1_HI;
  import rv_pkg::RS1_LO;
  import rv_pkg::RS2_HI;
  import rv_pkg::RS2_LO;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;

  logic ctl_redirect, ctl_pc_inc, ctl_load_mem, ctl_load_buf, ctl_bubble;
  logic ctl_buf_load, ctl_buf_consume;

  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;
  logic            buf_valid;

  fetch_hold_buf #(.PC_W(XLEN)) u_hold_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctl_buf_load),
    .clear    (ctl_redirect),
    .consume  (ctl_buf_consume),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .pc       (buf_pc),
    .instr    (buf_instr),
    .valid    (buf_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Redirect outranks stall; a redirect without a same-cycle response leaves one in flight.
  always_comb begin
    state_nxt = state;
    if (branch_taken) begin
      case (state)
        S_FETCH: state_nxt = imem_rvalid ? S_FETCH : S_DROP;
        S_HOLD:  state_nxt = S_FETCH;
        S_DROP:  state_nxt = imem_rvalid ? S_FETCH : S_DROP;
        default: state_nxt = S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: if (imem_rvalid && stall) state_nxt = S_HOLD;
        S_HOLD:  if (!stall) state_nxt = S_FETCH;
        S_DROP:  if (imem_rvalid) state_nxt = S_FETCH;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req        = rst_n && (state == S_FETCH);
    ctl_redirect    = branch_taken;
    ctl_pc_inc      = 1'b0;
    ctl_load_mem    = 1'b0;
    ctl_load_buf    = 1'b0;
    ctl_bubble      = 1'b0;
    ctl_buf_load    = 1'b0;
    ctl_buf_consume = 1'b0;
    if (!branch_taken) begin
      case (state)
        S_FETCH: begin
          if (imem_rvalid && !stall) begin
            ctl_load_mem = 1'b1;
            ctl_pc_inc   = 1'b1;
          end else if (imem_rvalid) begin
            ctl_buf_load = 1'b1;
          end else if (!stall) begin
            ctl_bubble = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ctl_load_buf    = 1'b1;
            ctl_buf_consume = 1'b1;
            ctl_pc_inc      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc <= RESET_PC;
    else if (ctl_redirect) pc <= branch_target;
    else if (ctl_pc_inc)   pc <= pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (ctl_redirect) begin
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (ctl_load_mem) begin
      IF_ID_pc    <= pc;
      IF_ID_instr <= imem_rdata;
      IF_ID_valid <= 1'b1;
    end else if (ctl_load_buf && buf_valid) begin
      IF_ID_pc    <= buf_pc;
      IF_ID_instr <= buf_instr;
      IF_ID_valid <= 1'b1;
    end else if (ctl_bubble) begin
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end
  end

  assign IF_ID_Rs1 = IF_ID_valid ? IF_ID_instr[RS1_HI:RS1_LO] : 5'd0;
  assign IF_ID_Rs2 = IF_ID_valid ? IF_ID_instr[RS2_HI:RS2_LO] : 5'd0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (stall && IF_ID_valid && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (branch_taken && (perf_redirect_cnt != 32'hFFFF_FFFF))
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, held response, redirect, reset, PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_Rs1;
  logic [4:0]  IF_ID_Rs2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  logic        zero_mode;
  logic        rvalid_m;
  logic [31:0] rdata_m;
  int          tests = 0;
  int          fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8) return 32'h0020_A183;
    return {a[11:0], 20'h00013};
  endfunction

  assign imem_rvalid = zero_mode ? imem_req : rvalid_m;
  assign imem_rdata  = zero_mode ? mem_fn(imem_addr) : rdata_m;

  fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_instr       (IF_ID_instr),
    .IF_ID_valid       (IF_ID_valid),
    .IF_ID_Rs1         (IF_ID_Rs1),
    .IF_ID_Rs2         (IF_ID_Rs2)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    zero_mode = 1'b1; rvalid_m = 1'b0; rdata_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(IF_ID_valid), 32'd0);
    chk("rst_instr", IF_ID_instr, NOP);
    chk("rst_pc", IF_ID_pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_rs1", 32'(IF_ID_Rs1), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_valid", 32'(IF_ID_valid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("stream_pc", IF_ID_pc, 32'(4 * (k - 1)));
      chk("stream_valid", 32'(IF_ID_valid), 32'd1);
      chk("stream_instr", IF_ID_instr, mem_fn(32'(4 * (k - 1))));
    end

    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_pc", IF_ID_pc, 32'h8);
      chk("stall_instr", IF_ID_instr, 32'h0020_A183);
      chk("stall_rs1", 32'(IF_ID_Rs1), 32'd1);
      chk("stall_rs2", 32'(IF_ID_Rs2), 32'd2);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_pc", IF_ID_pc, 32'hC);
    chk("unstall_valid", 32'(IF_ID_valid), 32'd1);
    chk("unstall_addr", imem_addr, 32'h10);

    zero_mode = 1'b0; rvalid_m = 1'b0;
    @(negedge clk);
    chk("bubble_valid", 32'(IF_ID_valid), 32'd0);
    chk("bubble_instr", IF_ID_instr, NOP);
    chk("wait_addr", imem_addr, 32'h10);
    chk("wait_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("wait2_req", 32'(imem_req), 32'd1);
    stall = 1'b1; rvalid_m = 1'b1; rdata_m = 32'h0031_0233;
    @(negedge clk);
    rvalid_m = 1'b0;
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_valid", 32'(IF_ID_valid), 32'd0);
    @(negedge clk);
    chk("hold2_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    chk("buf_pc", IF_ID_pc, 32'h10);
    chk("buf_instr", IF_ID_instr, 32'h0031_0233);
    chk("buf_rs1", 32'(IF_ID_Rs1), 32'd2);
    chk("buf_rs2", 32'(IF_ID_Rs2), 32'd3);
    chk("buf_next_addr", imem_addr, 32'h14);
    chk("buf_next_req", 32'(imem_req), 32'd1);

    zero_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_br_addr", imem_addr, 32'h20);
    chk("pre_br_pc", IF_ID_pc, 32'h1C);
    zero_mode = 1'b0; rvalid_m = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("br_valid", 32'(IF_ID_valid), 32'd0);
    chk("br_instr", IF_ID_instr, NOP);
    chk("br_pc", IF_ID_pc, 32'd0);
    chk("drop_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("drop2_req", 32'(imem_req), 32'd0);
    rvalid_m = 1'b1; rdata_m = 32'h0200_0093;
    @(negedge clk);
    rvalid_m = 1'b0;
    chk("after_drop_req", 32'(imem_req), 32'd1);
    chk("after_drop_addr", imem_addr, 32'h100);
    chk("after_drop_valid", 32'(IF_ID_valid), 32'd0);

    zero_mode = 1'b1;
    @(negedge clk);
    chk("tgt_pc", IF_ID_pc, 32'h100);
    chk("tgt_instr", IF_ID_instr, 32'h1000_0013);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("brstall_valid", 32'(IF_ID_valid), 32'd0);
    chk("brstall_instr", IF_ID_instr, NOP);
    chk("brstall_addr", imem_addr, 32'h200);
    chk("brstall_req", 32'(imem_req), 32'd1);

    @(negedge clk);
    chk("rhold_req", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rhold_valid", 32'(IF_ID_valid), 32'd0);
    chk("rhold_req_rst", 32'(imem_req), 32'd0);
    chk("rhold_addr", imem_addr, 32'd0);
    @(negedge clk);
    stall = 1'b0; rst_n = 1'b1;
    #1;
    chk("rerel_addr", imem_addr, 32'd0);
    chk("rerel_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("rerel_pc", IF_ID_pc, 32'd0);
    chk("rerel_valid", 32'(IF_ID_valid), 32'd1);
    chk("rerel_addr2", imem_addr, 32'h4);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc", IF_ID_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", IF_ID_instr, 32'hFFC0_0013);

    stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    chk("long_stall_pc", IF_ID_pc, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'd5);
    chk("perf_redirect", perf_redirect_cnt, 32'd1);
`endif
    @(negedge clk);
    chk("long_unstall_pc", IF_ID_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
